// File: rtl/sd_rx_block_buf.sv
// Receive-side block buffer: packs DAT-control bytes into 32-bit little-endian
// words tagged with end-of-block, stores them in a circular buffer, and drives
// the host pop port, block-available status and inter-block back-pressure.
module sd_rx_block_buf #(
  parameter int DEPTH_WORDS = 512
) (
  input  logic                           sdclk_i,
  input  logic                           rst_dat_i,
  input  logic [11:0]                    block_size_i,
  input  logic [7:0]                     r_data_i,
  input  logic                           r_valid_i,
  input  logic                           r_reset_i,
  output logic                           r_buf_full_o,
  output logic [31:0]                    rd_data_o,
  output logic                           rd_valid_o,
  input  logic                           rd_ready_i,
  output logic                           rd_last_o,
  output logic                           buf_read_enable_o,
  output logic                           overflow_o,
  output logic [$clog2(DEPTH_WORDS):0]   level_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = AW + 1;
  localparam int CW = (LW > 13) ? LW : 13;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH_WORDS);

  logic [32:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] blocks_q, blocks_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   hold_q, hold_d;
  logic [11:0]   byte_cnt_q, byte_cnt_d;
  logic          overflow_q, overflow_d;
  logic          full_q, full_d;

  logic          clr;
  logic          eob;
  logic          commit;
  logic          stored;
  logic          pop;
  logic [32:0]   head;
  logic [31:0]   word_d;
  logic [12:0]   need_sum;
  logic [12:0]   need_words;
  logic          full_rst;

  assign clr  = rst_dat_i | r_reset_i;
  assign head = mem_q[rd_ptr_q];

  // Packer: hold bytes are cleared on every commit, so unfilled lanes read as zero.
  always_comb begin
    eob      = r_valid_i && (byte_cnt_q == (block_size_i - 12'd1));
    commit   = r_valid_i && ((lane_q == 2'd3) || eob);
    word_d   = {8'h00, hold_q} | ({24'h000000, r_data_i} << {lane_q, 3'b000});
    lane_d   = lane_q;
    hold_d   = hold_q;
    byte_cnt_d = byte_cnt_q;
    if (r_valid_i) begin
      byte_cnt_d = eob ? 12'd0 : byte_cnt_q + 12'd1;
      lane_d     = eob ? 2'd0 : lane_q + 2'd1;
      if (commit) begin
        hold_d = 24'h000000;
      end else begin
        case (lane_q)
          2'd0:    hold_d[7:0]   = r_data_i;
          2'd1:    hold_d[15:8]  = r_data_i;
          default: hold_d[23:16] = r_data_i;
        endcase
      end
    end
  end

  // Storage bookkeeping; a pop frees its slot in the same cycle, so commit at full still lands.
  always_comb begin
    pop        = rd_valid_o & rd_ready_i;
    stored     = commit && ((level_q != DEPTH_L) || pop);
    overflow_d = commit && !stored;
    wr_ptr_d   = stored ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({stored, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    case ({stored && eob, pop && head[32]})
      2'b10:   blocks_d = blocks_q + LW'(1);
      2'b01:   blocks_d = blocks_q - LW'(1);
      default: blocks_d = blocks_q;
    endcase
  end

  // Block size 0 means 4096 bytes, i.e. 1024 words.
  always_comb begin
    need_sum   = {1'b0, block_size_i} + 13'd3;
    need_words = (block_size_i == 12'd0) ? 13'd1024 : (need_sum >> 2);
    full_d     = CW'(DEPTH_L - level_d) < CW'(need_words);
    full_rst   = CW'(DEPTH_L) < CW'(need_words);
  end

  always_ff @(posedge sdclk_i) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      blocks_q   <= '0;
      lane_q     <= 2'd0;
      hold_q     <= 24'h000000;
      byte_cnt_q <= 12'd0;
      overflow_q <= 1'b0;
      full_q     <= full_rst;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      blocks_q   <= blocks_d;
      lane_q     <= lane_d;
      hold_q     <= hold_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
    end
  end

  always_ff @(posedge sdclk_i) begin
    if (stored && !clr) begin
      mem_q[wr_ptr_q] <= {eob, word_d};
    end
  end

  assign rd_valid_o        = (level_q != '0);
  assign rd_data_o         = rd_valid_o ? head[31:0] : 32'h0;
  assign rd_last_o         = rd_valid_o & head[32];
  assign buf_read_enable_o = (blocks_q != '0);
  assign overflow_o        = overflow_q;
  assign r_buf_full_o      = full_q;
  assign level_o           = level_q;

endmodule
